// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
// Game-flow sequencer for the pong pixel/physics datapath. It holds the ball
// at home while idle, during the pre-serve countdown and in game-over. It
// enables physics during a rally, and it tracks lives, rally hits and the
// speed level.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   frame_tick      one-cycle pulse per video frame
//   start           one-cycle start request
//   hit, miss       one-cycle datapath events (miss wins over hit)
//   ball_hold       ball/paddle forced to home position
//   play_en         physics may advance
//   ball_speed      BASE_SPEED + current level (pixels/frame)
//   hit_count       hits this game, saturating
//   lives           balls remaining
//   game_over       high while in OVER
//   state           IDLE=0, SERVE=1, PLAY=2, OVER=3
// Every output is registered; next values are computed from the next state.
module pong_game_ctrl #(
  parameter int LIVES          = 3,
  parameter int SERVE_FRAMES   = 120,
  parameter int OVER_FRAMES    = 300,
  parameter int HITS_PER_LEVEL = 5,
  parameter int MAX_LEVEL      = 3,
  parameter int BASE_SPEED     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        hit,
  input  logic        miss,
  output logic        ball_hold,
  output logic        play_en,
  output logic [3:0]  ball_speed,
  output logic [15:0] hit_count,
  output logic [2:0]  lives,
  output logic        game_over,
  output logic [2:0]  state
);

  if (BASE_SPEED + MAX_LEVEL > 15) begin : g_speed_range_check
    $error("pong_game_ctrl: BASE_SPEED + MAX_LEVEL must fit in 4 bits");
  end

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3
  } state_t;

  state_t      state_r, state_s;
  logic [9:0]  frame_cnt_r, frame_cnt_s;
  logic [2:0]  level_r, level_s;
  logic [7:0]  lvl_cnt_r, lvl_cnt_s;
  logic [15:0] hit_count_s;
  logic [2:0]  lives_s;
  logic        ball_hold_s, play_en_s, game_over_s;
  logic [3:0]  ball_speed_s;

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      frame_cnt_r <= 10'd0;
      level_r     <= 3'd0;
      lvl_cnt_r   <= 8'd0;
      hit_count   <= 16'd0;
      lives       <= 3'(LIVES);
      ball_hold   <= 1'b1;
      play_en     <= 1'b0;
      game_over   <= 1'b0;
      ball_speed  <= 4'(BASE_SPEED);
    end else begin
      state_r     <= state_s;
      frame_cnt_r <= frame_cnt_s;
      level_r     <= level_s;
      lvl_cnt_r   <= lvl_cnt_s;
      hit_count   <= hit_count_s;
      lives       <= lives_s;
      ball_hold   <= ball_hold_s;
      play_en     <= play_en_s;
      game_over   <= game_over_s;
      ball_speed  <= ball_speed_s;
    end
  end

  assign state = state_r;

  // Next-state, counter and output decode.
  always_comb begin
    state_s     = state_r;
    frame_cnt_s = frame_cnt_r;
    level_s     = level_r;
    lvl_cnt_s   = lvl_cnt_r;
    hit_count_s = hit_count;
    lives_s     = lives;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s     = ST_SERVE;
          lives_s     = 3'(LIVES);
          hit_count_s = 16'd0;
          level_s     = 3'd0;
          lvl_cnt_s   = 8'd0;
          frame_cnt_s = 10'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SERVE: begin
        // The counter reaching N-1 means this tick is the N-th one.
        if (frame_tick) begin
          if (frame_cnt_r == 10'(SERVE_FRAMES - 1)) begin
            state_s     = ST_PLAY;
            frame_cnt_s = 10'd0;
          end else begin
            frame_cnt_s = frame_cnt_r + 10'd1;
          end
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
      end
      ST_PLAY: begin
        if (miss) begin
          lives_s     = lives - 3'd1;
          level_s     = 3'd0;
          lvl_cnt_s   = 8'd0;
          frame_cnt_s = 10'd0;
          if (lives == 3'd1) begin
            state_s = ST_OVER;
          end else begin
            state_s = ST_SERVE;
          end
        end else if (hit) begin
          if (hit_count != 16'hFFFF) begin
            hit_count_s = hit_count + 16'd1;
          end else begin
            hit_count_s = hit_count;
          end
          if (lvl_cnt_r == 8'(HITS_PER_LEVEL - 1)) begin
            lvl_cnt_s = 8'd0;
            if (level_r != 3'(MAX_LEVEL)) begin
              level_s = level_r + 3'd1;
            end else begin
              level_s = level_r;
            end
          end else begin
            lvl_cnt_s = lvl_cnt_r + 8'd1;
          end
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_OVER: begin
        lives_s = 3'd0;
        if (frame_tick) begin
          if (frame_cnt_r == 10'(OVER_FRAMES - 1)) begin
            state_s     = ST_IDLE;
            frame_cnt_s = 10'd0;
          end else begin
            frame_cnt_s = frame_cnt_r + 10'd1;
          end
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        frame_cnt_s = 10'd0;
      end
    endcase

    ball_hold_s  = (state_s != ST_PLAY);
    play_en_s    = (state_s == ST_PLAY);
    game_over_s  = (state_s == ST_OVER);
    ball_speed_s = 4'(BASE_SPEED) + {1'b0, level_s};
  end

endmodule
